// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter
//   Shares one data-memory port between the CPU memory stage and a DMA/loader
//   port. One access is in flight at a time (IDLE -> ACCESS -> RESP). The CPU
//   normally wins arbitration. The DMA wins once it has lost STARVE_LIMIT
//   consecutive contested arbitrations.
//
// Parameters
//   MEM_LAT       cycles from mem_en to mem_rdata capture (1..7)
//   STARVE_LIMIT  consecutive DMA losses before the DMA is forced through (1..15)
//
// Ports
//   clk, rst (async, active-low)
//   cpu_req/we/addr/wdata  in   CPU request and payload
//   cpu_stall              out  cpu_req & ~cpu_done (combinational)
//   cpu_done/err/rdata     out  completion pulse, misalign flag, load data
//   dma_*                  same meaning for the DMA port (no stall output)
//   mem_en/we/addr/wdata   out  memory strobe and held payload
//   mem_rdata              in   memory read data
module dmem_arbiter #(
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_stall,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic [31:0] cpu_rdata,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_done,
   output logic        dma_err,
   output logic [31:0] dma_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;

   localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
   localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

   stateT       state;
   logic [3:0]  starveCnt;
   logic [2:0]  latCnt;
   logic        latWe;
   logic        latDma;
   logic        latMis;

   logic        anyReq;
   logic        dmaWins;
   logic        selWe;
   logic [31:0] selAddr;
   logic [31:0] selWdata;
   logic        selMis;

   assign anyReq   = cpu_req | dma_req;
   // A lone DMA request always wins; a contested one only once starved.
   assign dmaWins  = dma_req & (~cpu_req | (starveCnt >= LIMIT));
   assign selWe    = dmaWins ? dma_we    : cpu_we;
   assign selAddr  = dmaWins ? dma_addr  : cpu_addr;
   assign selWdata = dmaWins ? dma_wdata : cpu_wdata;
   assign selMis   = (selAddr[1:0] != 2'b00);

   assign cpu_stall = cpu_req & ~cpu_done;

   // mem_addr/mem_wdata double as the payload latch: they are loaded at grant,
   // held through ACCESS and cleared on the way to RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         starveCnt <= '0;
         latCnt    <= '0;
         latWe     <= 1'b0;
         latDma    <= 1'b0;
         latMis    <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_done  <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= '0;
         dma_done  <= 1'b0;
         dma_err   <= 1'b0;
         dma_rdata <= '0;
      end else begin
         mem_en   <= 1'b0;
         cpu_done <= 1'b0;
         cpu_err  <= 1'b0;
         dma_done <= 1'b0;
         dma_err  <= 1'b0;

         if (!dma_req) begin
            starveCnt <= '0;
         end else if (state == IDLE && anyReq) begin
            if (dmaWins)
               starveCnt <= '0;
            else if (starveCnt != 4'd15)
               starveCnt <= starveCnt + 4'd1;
         end

         case (state)
            IDLE: begin
               if (anyReq) begin
                  latWe     <= selWe;
                  latDma    <= dmaWins;
                  latMis    <= selMis;
                  latCnt    <= LAT_INIT;
                  mem_en    <= ~selMis;
                  mem_we    <= selWe;
                  mem_addr  <= selAddr;
                  mem_wdata <= selWdata;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               // Misaligned accesses never touch memory, so skip the wait.
               if (latMis || latCnt == 3'd0) begin
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  if (latDma) begin
                     dma_done <= 1'b1;
                     dma_err  <= latMis;
                     if (!latWe && !latMis)
                        dma_rdata <= mem_rdata;
                  end else begin
                     cpu_done <= 1'b1;
                     cpu_err  <= latMis;
                     if (!latWe && !latMis)
                        cpu_rdata <= mem_rdata;
                  end
                  state <= RESP;
               end else begin
                  latCnt <= latCnt - 3'd1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
